// File: rtl/max_tree_in_packer.sv
// Serial-to-parallel packer feeding the n-input signed max tree: collects one
// point per beat into a window vector, padding unused slots with the most-negative value.

module max_tree_in_packer_slot #(
    parameter int cmp_width = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 en,
    input  logic                 wr,
    input  logic                 clr,
    input  logic [cmp_width-1:0] d,
    output logic [cmp_width-1:0] q
);
    localparam logic [cmp_width-1:0] NEG = {1'b1, {(cmp_width-1){1'b0}}};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)    q <= NEG;
        else if (en) begin
            if (clr)     q <= NEG;
            else if (wr) q <= d;
        end
    end
endmodule

module max_tree_in_packer #(
    parameter int cmp_input_n      = 4,
    parameter int cmp_width        = 8,
    parameter int simulation_delay = 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             aclken,
    input  logic [5:0]                       cfg_grp_len,
    input  logic [cmp_width-1:0]             s_axis_data,
    input  logic                             s_axis_last,
    input  logic                             s_axis_valid,
    output logic                             s_axis_ready,
    output logic [cmp_input_n*cmp_width-1:0] cmp_in,
    output logic                             cmp_in_vld,
    output logic                             cmp_in_last,
    output logic [15:0]                      grp_cnt
);
    localparam int             FW  = (cmp_input_n > 1) ? $clog2(cmp_input_n) : 1;
    localparam logic [6:0]     N7  = 7'(cmp_input_n);
    localparam logic [cmp_width-1:0] NEG = {1'b1, {(cmp_width-1){1'b0}}};

    logic [FW-1:0] fill_cnt, last_idx_r, cfg_idx, cur_idx;
    logic [6:0]    cfg_len;
    logic          accept, close;
    logic [cmp_input_n-1:0][cmp_width-1:0] asm_q, merged;

    // The register only models timing in simulation; keep it referenced.
    logic unused_sim;
    assign unused_sim = (simulation_delay != 0);

    assign s_axis_ready = aclken;
    assign accept       = s_axis_valid & aclken;

    // Window length is sampled on the first beat; mid-window cfg changes wait.
    always_comb begin
        cfg_len = {1'b0, cfg_grp_len};
        if (cfg_grp_len == 6'd0 || {1'b0, cfg_grp_len} > N7) cfg_len = N7;
        cfg_idx = FW'(cfg_len - 7'd1);
        cur_idx = (fill_cnt == '0) ? cfg_idx : last_idx_r;
    end

    assign close = accept & ((fill_cnt == cur_idx) | s_axis_last);

    genvar i;
    generate
        for (i = 0; i < cmp_input_n; i++) begin : g_slot
            max_tree_in_packer_slot #(.cmp_width(cmp_width)) u_slot (
                .aclk    (aclk),
                .aresetn (aresetn),
                .en      (aclken),
                .wr      (accept & ~close & (fill_cnt == FW'(i))),
                .clr     (close),
                .d       (s_axis_data),
                .q       (asm_q[i])
            );
            // Final beat bypasses the assembly reg; slots beyond it pad with NEG.
            assign merged[i] = (FW'(i) < fill_cnt)  ? asm_q[i]    :
                               (FW'(i) == fill_cnt) ? s_axis_data : NEG;
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fill_cnt    <= '0;
            last_idx_r  <= '0;
            cmp_in      <= {cmp_input_n{NEG}};
            cmp_in_vld  <= 1'b0;
            cmp_in_last <= 1'b0;
            grp_cnt     <= 16'd0;
        end else if (aclken) begin
            if (accept) begin
                if (fill_cnt == '0) last_idx_r <= cfg_idx;
                if (close) begin
                    cmp_in      <= merged;
                    cmp_in_vld  <= 1'b1;
                    cmp_in_last <= s_axis_last;
                    grp_cnt     <= grp_cnt + 16'd1;
                    fill_cnt    <= '0;
                end else begin
                    cmp_in_vld  <= 1'b0;
                    fill_cnt    <= fill_cnt + FW'(1);
                end
            end else begin
                cmp_in_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_max_tree_in_packer.sv
// Bench for max_tree_in_packer: n=4 and n=8 instances share one stimulus stream
// and are compared each cycle against a window-level queue model.
module tb_max_tree_in_packer;
    localparam logic [7:0] NEG = 8'h80;

    logic        aclk = 1'b0;
    logic        aresetn, aclken, s_last, s_valid;
    logic [5:0]  cfg;
    logic [7:0]  s_data;
    logic        rdy4, rdy8, vld4, vld8, last4, last8;
    logic [31:0] cmp4;
    logic [63:0] cmp8;
    logic [15:0] gc4, gc8;

    int checks = 0, failures = 0;

    // Model state per instance: k=0 is n=4, k=1 is n=8.
    logic [7:0]  m_pts [2][32];
    int          m_cnt [2];
    int          m_len [2];
    logic [63:0] m_cmp [2];
    logic        m_vld [2];
    logic        m_last[2];
    logic [15:0] m_grp [2];

    always #5 aclk = ~aclk;

    max_tree_in_packer #(.cmp_input_n(4), .cmp_width(8), .simulation_delay(1)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .cfg_grp_len(cfg),
        .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_valid(s_valid),
        .s_axis_ready(rdy4), .cmp_in(cmp4), .cmp_in_vld(vld4),
        .cmp_in_last(last4), .grp_cnt(gc4));

    max_tree_in_packer #(.cmp_input_n(8), .cmp_width(8), .simulation_delay(1)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .cfg_grp_len(cfg),
        .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_valid(s_valid),
        .s_axis_ready(rdy8), .cmp_in(cmp8), .cmp_in_vld(vld8),
        .cmp_in_last(last8), .grp_cnt(gc8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_len[k] = 0; m_vld[k] = 0; m_last[k] = 0; m_grp[k] = 0;
            m_cmp[k] = '0;
            for (int i = 0; i < 4 * (k + 1); i++) m_cmp[k][i*8 +: 8] = NEG;
        end
    endtask

    task automatic model_step(input int k, input int n);
        if (!aclken) return;
        if (!s_valid) begin
            m_vld[k] = 0;
            return;
        end
        if (m_cnt[k] == 0) m_len[k] = (cfg == 0 || int'(cfg) > n) ? n : int'(cfg);
        m_pts[k][m_cnt[k]] = s_data;
        m_cnt[k]++;
        if (m_cnt[k] == m_len[k] || s_last) begin
            m_cmp[k] = '0;
            for (int i = 0; i < n; i++) m_cmp[k][i*8 +: 8] = (i < m_cnt[k]) ? m_pts[k][i] : NEG;
            m_vld[k]  = 1;
            m_last[k] = s_last;
            m_grp[k]  = m_grp[k] + 16'd1;
            m_cnt[k]  = 0;
        end else begin
            m_vld[k] = 0;
        end
    endtask

    task automatic check_outputs();
        chk("cmp4",  {32'b0, cmp4}, m_cmp[0]);
        chk("vld4",  64'(vld4),     64'(m_vld[0]));
        chk("last4", 64'(last4),    64'(m_last[0]));
        chk("grp4",  64'(gc4),      64'(m_grp[0]));
        chk("cmp8",  cmp8,          m_cmp[1]);
        chk("vld8",  64'(vld8),     64'(m_vld[1]));
        chk("last8", 64'(last8),    64'(m_last[1]));
        chk("grp8",  64'(gc8),      64'(m_grp[1]));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic en);
        @(negedge aclk);
        s_valid = v; s_data = d; s_last = l; aclken = en;
        #1;
        chk("rdy4", 64'(rdy4), 64'(en));
        chk("rdy8", 64'(rdy8), 64'(en));
        model_step(0, 4);
        model_step(1, 8);
        @(posedge aclk);
        #1;
        check_outputs();
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        step(1'b1, d, l, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0; s_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b1; aclken = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        s_data = 8'h00; cfg = 6'd4;
        model_reset();
        do_reset();

        // 1: full window of four
        cfg = 6'd4;
        beat(8'd3, 0); beat(-8'sd7, 0); beat(8'd12, 0); beat(8'd5, 0);
        chk("t1_cmp4", {32'b0, cmp4}, {32'b0, 8'd5, 8'd12, -8'sd7, 8'd3});
        idle(2);

        // 2: short window closed by last
        beat(-8'sd1, 0); beat(-8'sd2, 1);
        chk("t2_cmp4", {32'b0, cmp4}, {32'b0, NEG, NEG, -8'sd2, -8'sd1});
        chk("t2_last", 64'(last4), 64'd1);
        idle(1);

        // 3: cfg 0 and cfg 9 both clamp to the full width
        cfg = 6'd0;
        for (int i = 0; i < 8; i++) beat(8'(i * 9 - 20), 0);
        cfg = 6'd9;
        for (int i = 0; i < 8; i++) beat(8'(50 - i * 7), 0);
        idle(1);

        // 4: L=1 back-to-back
        do_reset();
        cfg = 6'd1;
        for (int i = 0; i < 5; i++) beat(8'(i + 1), 0);
        chk("t4_grp", 64'(gc4), 64'd5);
        idle(1);

        // 5: clock enable low mid-window and after a window
        cfg = 6'd4;
        beat(8'd10, 0); beat(8'd20, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h7f, 1'b0, 1'b0);
        beat(8'd30, 0); beat(8'd40, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h7f, 1'b1, 1'b0);
        chk("t5_cmp4", {32'b0, cmp4}, {32'b0, 8'd40, 8'd30, 8'd20, 8'd10});
        idle(1);

        // 6: reset discards a partial window
        beat(8'd1, 0); beat(8'd2, 0);
        do_reset();
        beat(8'd11, 0); beat(8'd12, 0); beat(8'd13, 0); beat(8'd14, 0);
        chk("t6_cmp4", {32'b0, cmp4}, {32'b0, 8'd14, 8'd13, 8'd12, 8'd11});
        idle(1);

        // Random traffic with mid-window cfg changes and stalls
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cfg = 6'($urandom_range(0, 10));
            step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 85);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
